// File: rtl/rpi_link_pkg.sv
// Shared definitions for the Raspberry Pi GPIO nibble link.
// Pure constants and types; no logic, no latency, no flow control.
package rpi_link_pkg;

   localparam logic ST_IDLE    = 1'b0;
   localparam logic ST_WAIT_LO = 1'b1;

   localparam int DEFAULT_TIMEOUT_CYCLES = 50_000_000;
   localparam int NIBBLE_W               = 4;

   typedef enum logic {
      S_IDLE    = ST_IDLE,
      S_WAIT_LO = ST_WAIT_LO
   } state_t;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a bus of independent async bits.
// Latency DEPTH cycles; no flow control, samples every cycle.
module bit_sync #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] async_bits,
   output logic [WIDTH-1:0] sync_bits
);

   logic [WIDTH-1:0] stages [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stages[i] <= '0;
         end
      end else begin
         stages[0] <= async_bits;
         for (int i = 1; i < DEPTH; i++) begin
            stages[i] <= stages[i-1];
         end
      end
   end

   assign sync_bits = stages[DEPTH-1];

endmodule

// File: rtl/rpi_nibble_rx.sv
// Assembles two strobed Pi nibbles (high first) into a byte with a 1-cycle valid pulse.
// Latency SYNC_STAGES+1 cycles from strobe rise; no back-pressure, byte held until the next one.
module rpi_nibble_rx
   import rpi_link_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                in_clk,
   input  logic                in_rst,
   input  logic                in_func,
   input  logic [NIBBLE_W-1:0] in_data,
   output logic [7:0]          out_data,
   output logic                out_valid,
   output logic                out_ack,
   output logic [7:0]          out_count,
   output logic                out_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [NIBBLE_W:0]   synced;
   logic                func_prev;
   logic                strobe_edge;
   logic [NIBBLE_W-1:0] nibble;
   logic [NIBBLE_W-1:0] hi;
   logic [TW-1:0]       timer;
   state_t              state;

   bit_sync #(
      .WIDTH (NIBBLE_W + 1),
      .DEPTH (SYNC_STAGES)
   ) u_sync (
      .clk        (in_clk),
      .rst        (in_rst),
      .async_bits ({in_func, in_data}),
      .sync_bits  (synced)
   );

   assign strobe_edge = synced[NIBBLE_W] & ~func_prev;
   assign nibble      = synced[NIBBLE_W-1:0];

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state     <= S_IDLE;
         func_prev <= 1'b0;
         hi        <= '0;
         timer     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_ack   <= 1'b0;
         out_count <= '0;
         out_err   <= 1'b0;
      end else begin
         func_prev <= synced[NIBBLE_W];
         out_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (strobe_edge) begin
                  hi      <= nibble;
                  timer   <= '0;
                  state   <= S_WAIT_LO;
                  out_ack <= 1'b1;
               end
            end
            S_WAIT_LO: begin
               // A strobe edge on the final timer cycle still completes the byte.
               if (strobe_edge) begin
                  out_data  <= {hi, nibble};
                  out_valid <= 1'b1;
                  out_count <= out_count + 8'd1;
                  out_err   <= 1'b0;
                  state     <= S_IDLE;
                  out_ack   <= 1'b0;
               end else if (timer == TIMER_LAST) begin
                  out_err <= 1'b1;
                  hi      <= '0;
                  state   <= S_IDLE;
                  out_ack <= 1'b0;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            default: begin
               state   <= S_IDLE;
               out_ack <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rpi_nibble_rx.sv
// Directed bench for rpi_nibble_rx: behavioural byte-assembly model checked every cycle,
// plus literal expectations for latency, timeout, wrap, reset and strobe corner cases.
module tb_rpi_nibble_rx;

   localparam int S  = 2;
   localparam int TO = 16;

   logic       in_clk  = 1'b0;
   logic       in_rst  = 1'b1;
   logic       in_func = 1'b0;
   logic [3:0] in_data = 4'h0;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ack;
   logic [7:0] out_count;
   logic       out_err;

   int vectors     = 0;
   int miscompares = 0;
   int pulses      = 0;
   bit chk_en      = 1'b0;

   // behavioural model state
   bit       fh [8];
   bit [3:0] dh [8];
   bit       have_hi;
   bit [3:0] m_hi;
   int       elapsed;
   bit [7:0] m_data;
   bit [7:0] m_cnt;
   bit       m_valid;
   bit       m_err;

   rpi_nibble_rx #(
      .SYNC_STAGES    (S),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .in_clk    (in_clk),
      .in_rst    (in_rst),
      .in_func   (in_func),
      .in_data   (in_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ack   (out_ack),
      .out_count (out_count),
      .out_err   (out_err)
   );

   always #5 in_clk = ~in_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // A strobe counts once the Pi's rising edge has crossed S synchroniser samples.
   task automatic model_step();
      bit       det;
      bit [3:0] nib;
      for (int i = 7; i > 0; i--) begin
         fh[i] = fh[i-1];
         dh[i] = dh[i-1];
      end
      fh[0] = in_func;
      dh[0] = in_data;
      det = fh[S] && !fh[S+1];
      nib = dh[S];
      if (in_rst) begin
         have_hi = 0; m_hi = 0; elapsed = 0;
         m_data = 0; m_cnt = 0; m_valid = 0; m_err = 0;
      end else begin
         m_valid = 0;
         if (!have_hi) begin
            if (det) begin
               have_hi = 1; m_hi = nib; elapsed = 0;
            end
         end else if (det) begin
            m_data  = {m_hi, nib};
            m_valid = 1;
            m_cnt   = m_cnt + 8'd1;
            m_err   = 0;
            have_hi = 0;
         end else begin
            elapsed++;
            if (elapsed == TO) begin
               m_err = 1; have_hi = 0; m_hi = 0;
            end
         end
      end
   endtask

   always @(posedge in_clk) model_step();

   always @(negedge in_clk) begin
      if (chk_en) begin
         check("out_data",  out_data,  m_data);
         check("out_valid", out_valid, m_valid);
         check("out_ack",   out_ack,   have_hi);
         check("out_count", out_count, m_cnt);
         check("out_err",   out_err,   m_err);
         if (out_valid === 1'b1) pulses++;
      end
   end

   task automatic tick();
      @(posedge in_clk);
      #1;
   endtask

   // Data is set one cycle ahead of the strobe; lat = edges until out_valid is seen.
   task automatic send_nib(input logic [3:0] n, input int hi_t, input int lo_t, output int lat);
      in_data = n;
      tick();
      in_func = 1'b1;
      lat = -1;
      for (int i = 1; i <= hi_t; i++) begin
         tick();
         if (out_valid === 1'b1 && lat < 0) lat = i;
      end
      in_func = 1'b0;
      repeat (lo_t) tick();
   endtask

   initial begin
      int lat, t, n, p0;
      logic [7:0] bv;

      repeat (3) tick();
      in_rst = 1'b0;
      chk_en = 1'b1;
      check("rst_data",  out_data,  8'h00);
      check("rst_count", out_count, 8'h00);
      check("rst_ack",   out_ack,   1'b0);
      check("rst_err",   out_err,   1'b0);

      // single byte A5
      p0 = pulses;
      send_nib(4'hA, 8, 4, lat);
      check("ack_after_hi", out_ack, 1'b1);
      send_nib(4'h5, 8, 8, lat);
      check("lat_lo", lat, S + 1);
      check("byte_a5", out_data, 8'hA5);
      check("count_1", out_count, 8'd1);
      check("ack_after_lo", out_ack, 1'b0);
      check("pulses_a5", pulses - p0, 1);

      // timeout after 16 cycles in WAIT_LO
      in_data = 4'h3;
      tick();
      in_func = 1'b1;
      t = 0;
      while (out_ack !== 1'b1 && t < 20) begin tick(); t++; end
      check("ack_latency", t, S + 1);
      n = 0;
      while (out_err !== 1'b1 && n < 40) begin tick(); n++; end
      check("timeout_cycles", n, TO);
      check("to_ack", out_ack, 1'b0);
      check("to_count", out_count, 8'd1);
      check("to_data", out_data, 8'hA5);
      in_func = 1'b0;
      repeat (4) tick();
      send_nib(4'h1, 4, 4, lat);
      send_nib(4'h2, 4, 4, lat);
      check("byte_12", out_data, 8'h12);
      check("err_cleared", out_err, 1'b0);
      check("count_2", out_count, 8'd2);

      // low-nibble edge lands exactly on the timeout cycle
      in_data = 4'h6;
      tick();
      in_func = 1'b1;
      t = 0;
      while (out_ack !== 1'b1 && t < 20) begin tick(); t++; end
      repeat (3) tick();
      in_func = 1'b0;
      repeat (9) tick();
      in_data = 4'h9;
      tick();
      in_func = 1'b1;
      repeat (3) tick();
      check("edge_wins_valid", out_valid, 1'b1);
      check("edge_wins_data", out_data, 8'h69);
      check("edge_wins_err", out_err, 1'b0);
      check("count_3", out_count, 8'd3);
      repeat (2) tick();
      in_func = 1'b0;
      repeat (4) tick();

      // strobe held high for 100 cycles: one nibble only, then timeout
      p0 = pulses;
      in_data = 4'h7;
      tick();
      in_func = 1'b1;
      repeat (10) tick();
      check("long_ack", out_ack, 1'b1);
      repeat (90) tick();
      check("long_no_byte", pulses - p0, 0);
      check("long_err", out_err, 1'b1);
      in_func = 1'b0;
      repeat (5) tick();

      // one-cycle glitch, then a clean byte must decode
      in_data = 4'h4;
      tick();
      in_func = 1'b1;
      tick();
      in_func = 1'b0;
      repeat (20) tick();
      send_nib(4'hC, 4, 4, lat);
      send_nib(4'h3, 4, 4, lat);
      check("glitch_byte", out_data, 8'hC3);
      check("glitch_err", out_err, 1'b0);

      // reset while WAIT_LO
      send_nib(4'h9, 4, 4, lat);
      check("mid_ack", out_ack, 1'b1);
      in_rst = 1'b1;
      tick();
      in_rst = 1'b0;
      check("mrst_data",  out_data,  8'h00);
      check("mrst_count", out_count, 8'h00);
      check("mrst_ack",   out_ack,   1'b0);
      check("mrst_valid", out_valid, 1'b0);
      send_nib(4'hF, 4, 4, lat);
      send_nib(4'h0, 4, 4, lat);
      check("byte_f0", out_data, 8'hF0);
      check("lat_f0", lat, S + 1);
      check("count_after_rst", out_count, 8'd1);

      // 256 bytes wrap the counter
      in_rst = 1'b1;
      tick();
      in_rst = 1'b0;
      p0 = pulses;
      for (int b = 0; b < 256; b++) begin
         bv = 8'(b);
         send_nib(bv[7:4], 4, 4, lat);
         send_nib(bv[3:0], 4, 4, lat);
      end
      check("wrap_pulses", pulses - p0, 256);
      check("wrap_count", out_count, 8'd0);
      check("wrap_data", out_data, 8'hFF);

      repeat (3) tick();
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1);
   end

endmodule

// File: doc/rpi_nibble_rx.md
# rpi_nibble_rx

Upstream receive stage for the Raspberry Pi GPIO link. It synchronises the Pi's 4-bit data bus and `in_func` strobe into the `in_clk` domain. Two strobed nibbles, high nibble first, are assembled into one byte. The byte is presented with a one-cycle valid pulse to the display path (`seg` decoder, LED bank). The block also returns a phase acknowledge to the Pi and flags incomplete transfers.

## Interface
- `SYNC_STAGES`, 2: flip-flop depth of the input synchroniser; legal range is 2 to 4.
- `TIMEOUT_CYCLES`, 50_000_000: maximum number of `in_clk` cycles allowed between the high and low nibble (1 s at 50 MHz); must be ≥ 2.
- `in_clk`  input  1  system clock (50 MHz board oscillator).
- `in_rst`  input  1  reset; synchronous to `in_clk`, active-high.
- `in_func`  input  1  asynchronous nibble strobe from the Pi; data is valid on its rising edge.
- `in_data`  input  4  asynchronous nibble bus from the Pi.
- `out_data`  output  8  last completed byte `{hi, lo}`; held until the next byte completes.
- `out_valid`  output  1  one-cycle pulse when `out_data` updates.
- `out_ack`  output  1  nibble phase back to the Pi; 1 = high nibble held, waiting for low.
- `out_count`  output  8  number of completed bytes, modulo 256.
- `out_err`  output  1  sticky timeout flag.

## Operation
- **Synchroniser:** `in_func` and `in_data` each pass through `SYNC_STAGES` flops. One further register holds the previous synchronised strobe. A rising edge is defined as synchronised strobe = 1 while the previous value = 0. The nibble is taken from the synchronised `in_data` on the same cycle.
- **State machine:**
  - IDLE, on edge: capture the nibble into `hi`, clear the timer, go to WAIT_LO.
  - WAIT_LO, on edge:
    - load `out_data` <= `{hi, nibble}`;
    - pulse `out_valid`;
    - `out_count` <= `out_count` + 1, wrapping 255 -> 0;
    - clear `out_err`;
    - go to IDLE.
  - WAIT_LO, no edge: increment the timer. When the timer = `TIMEOUT_CYCLES`-1, set `out_err`, discard `hi` and go to IDLE. `out_data` and `out_count` are unchanged.
- **Edge on the timeout cycle:** the edge wins. The low nibble is accepted and `out_err` is not set.
- **`out_ack`:** registered and equal to (state == WAIT_LO).
- **Strobe held high:** produces no further edges; only one nibble is taken per rising edge.
- **Reset, including mid-byte:** next state IDLE, and `hi`, the timer and every output go to 0. This covers `out_data`, `out_valid`, `out_ack`, `out_count` and `out_err`. An edge present in the reset cycle is ignored.
- **Timer width:** $clog2(`TIMEOUT_CYCLES`) bits; it never wraps.

## Timing
- **Detection latency:** with `in_func` rising before in_clk edge 0, the strobe edge is detected (state update) at edge `SYNC_STAGES`+1.
- **`out_valid` latency:** `out_valid`, `out_data`, `out_count` and `out_ack` are visible after edge `SYNC_STAGES`+1. That is 3 cycles of latency at the default depth.
- **Pi-side constraint:** the Pi holds `in_data` stable from at least 1 `in_clk` cycle before the strobe rises until `SYNC_STAGES`+1 cycles after it. `in_func` high and low times must each be ≥ `SYNC_STAGES`+1 cycles; shorter pulses may be lost.
- **Maximum throughput:** one nibble per 2·(`SYNC_STAGES`+1) cycles.
- **Pi handshake:** the Pi may wait on `out_ack` (full handshake) or use fixed delays.
- **Downstream interface:** `out_valid` has no back-pressure; consumers must take the byte on the pulse or read the held `out_data`.

## Structure
- **Shared package `rpi_link_pkg`:**
  - state encoding localparams `ST_IDLE` = 1'b0 and `ST_WAIT_LO` = 1'b1;
  - default `TIMEOUT_CYCLES`;
  - nibble width constant 4.
- **Sub-module `bit_sync`:** parameterised width and depth; one instance covers `in_func` and `in_data` together (width 5).
- **Top-level integration:** the board top replaces its direct `in_data` -> `seg`/LED path with `out_data` from this block.

## Test plan
- **Single byte:** after reset, strobe nibble 0xA then 0x5 with 8-cycle high/low times -> `out_data` = 0xA5 with a 1-cycle `out_valid`; `out_count` = 1; `out_ack` goes 1 after the first strobe and 0 after the second.
- **Timeout:** set `TIMEOUT_CYCLES`=16; strobe 0x3, then no strobe for 20 cycles -> `out_err` = 1 exactly 16 cycles after entering WAIT_LO; `out_ack` = 0; `out_count` unchanged. Then send 0x1, 0x2 -> `out_data` = 0x12 and `out_err` clears.
- **Edge on the timeout cycle:** the low-nibble edge is detected on the timeout cycle -> the byte completes and `out_err` stays 0.
- **Count wrap:** send 256 bytes -> `out_count` returns to 0, with exactly 256 `out_valid` pulses.
- **Reset mid-byte and long strobe:**
  - Assert `in_rst` for one cycle while in WAIT_LO -> all outputs 0. Then send 0xF, 0x0 -> `out_data` = 0xF0.
  - Hold `in_func` high for 100 cycles -> exactly one nibble is accepted.
- **Timing and glitch rejection:**
  - Check latency: `out_valid` appears exactly `SYNC_STAGES`+1 edges after the low-nibble strobe is sampled high.
  - A 1-cycle strobe glitch with `SYNC_STAGES`=2 is not guaranteed to be captured; the bench must check only that the state machine still decodes correctly afterwards.
